// File: rtl/wb_resize_pkg.sv
// Shared definitions for the Wishbone width bridges: FSM state encoding,
// endian selectors and the byte-lane helper functions.
package wb_resize_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam string endian_big    = "big";
   localparam string endian_little = "little";

   // Byte offset within a word to lane index; big endian mirrors the offset.
   function automatic logic [1:0] lane(input logic [1:0] a, input logic big);
      return big ? 2'(2'd3 - a) : a;
   endfunction

   // One-hot byte select for a lane.
   function automatic logic [3:0] byte_sel(input logic [1:0] l);
      return 4'(4'b0001 << l);
   endfunction

endpackage

// File: rtl/wb_data_upsize.sv
// 8-bit Wishbone master onto a 32-bit Wishbone slave.
// A one-word read buffer serves sequential byte reads from the same word
// without a slave access; writes go straight through as single-lane writes.
// Ports:
//   wb_clk_i, wb_rst_i         clock, synchronous active-high reset
//   inv_i                      invalidate the read buffer
//   wbm_*                      8-bit master side (cti/bte ignored)
//   wbs_*                      32-bit classic slave side, word addressed
module wb_data_upsize
   import wb_resize_pkg::*;
#(
   parameter int unsigned aw     = 32,
   parameter string       endian = "big"
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic          inv_i,
   input  logic [aw-1:0] wbm_adr_i,
   input  logic [7:0]    wbm_dat_i,
   input  logic          wbm_we_i,
   input  logic          wbm_cyc_i,
   input  logic          wbm_stb_i,
   input  logic [2:0]    wbm_cti_i,
   input  logic [1:0]    wbm_bte_i,
   output logic [7:0]    wbm_dat_o,
   output logic          wbm_ack_o,
   output logic          wbm_err_o,
   output logic          wbm_rty_o,
   output logic [aw-1:0] wbs_adr_o,
   output logic [31:0]   wbs_dat_o,
   output logic [3:0]    wbs_sel_o,
   output logic          wbs_we_o,
   output logic          wbs_cyc_o,
   output logic          wbs_stb_o,
   output logic [2:0]    wbs_cti_o,
   output logic [1:0]    wbs_bte_o,
   input  logic [31:0]   wbs_dat_i,
   input  logic          wbs_ack_i,
   input  logic          wbs_err_i,
   input  logic          wbs_rty_i
);

   localparam bit          is_big = (endian != endian_little);
   localparam int unsigned tw     = aw - 2;

   state_t         state;
   logic           buf_valid;
   logic [tw-1:0]  buf_tag;
   logic [31:0]    buf_data;
   logic [1:0]     lane_q;

   logic           req_c;
   logic [1:0]     req_lane_c;
   logic           hit_c;
   logic           unused_ok;

   assign wbs_cti_o = 3'b000;
   assign wbs_bte_o = 2'b00;
   assign unused_ok = ^{wbm_cti_i, wbm_bte_i};

   assign req_c      = wbm_cyc_i & wbm_stb_i;
   assign req_lane_c = lane(wbm_adr_i[1:0], is_big);
   // inv_i in the request cycle forces the access to the slave.
   assign hit_c      = !wbm_we_i && buf_valid && !inv_i &&
                       (buf_tag == wbm_adr_i[aw-1:2]);

   // Bridge FSM; every output and the read buffer are registered here.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= IDLE;
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= '0;
         lane_q    <= '0;
         wbm_dat_o <= '0;
         wbm_ack_o <= 1'b0;
         wbm_err_o <= 1'b0;
         wbm_rty_o <= 1'b0;
         wbs_adr_o <= '0;
         wbs_dat_o <= '0;
         wbs_sel_o <= '0;
         wbs_we_o  <= 1'b0;
         wbs_cyc_o <= 1'b0;
         wbs_stb_o <= 1'b0;
      end else begin
         // Later assignments (a read fill) override this clear.
         if (inv_i) buf_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (req_c) begin
                  lane_q <= req_lane_c;
                  if (hit_c) begin
                     wbm_dat_o <= buf_data[8*req_lane_c +: 8];
                     wbm_ack_o <= 1'b1;
                     state     <= RESP;
                  end else begin
                     wbs_adr_o <= {wbm_adr_i[aw-1:2], 2'b00};
                     wbs_cyc_o <= 1'b1;
                     wbs_stb_o <= 1'b1;
                     if (wbm_we_i) begin
                        wbs_dat_o <= {4{wbm_dat_i}};
                        wbs_sel_o <= byte_sel(req_lane_c);
                        wbs_we_o  <= 1'b1;
                        state     <= WR;
                     end else begin
                        wbs_sel_o <= 4'b1111;
                        wbs_we_o  <= 1'b0;
                        state     <= RD;
                     end
                  end
               end
            end

            RD: begin
               if (!wbm_cyc_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  buf_valid <= 1'b0;
                  state     <= IDLE;
               end else if (wbs_err_i || wbs_rty_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  buf_valid <= 1'b0;
                  wbm_err_o <= wbs_err_i;
                  wbm_rty_o <= !wbs_err_i;
                  state     <= RESP;
               end else if (wbs_ack_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  buf_data  <= wbs_dat_i;
                  buf_tag   <= wbs_adr_o[aw-1:2];
                  buf_valid <= 1'b1;
                  wbm_dat_o <= wbs_dat_i[8*lane_q +: 8];
                  wbm_ack_o <= 1'b1;
                  state     <= RESP;
               end
            end

            WR: begin
               if (!wbm_cyc_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  state     <= IDLE;
               end else if (wbs_err_i || wbs_rty_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  buf_valid <= 1'b0;
                  wbm_err_o <= wbs_err_i;
                  wbm_rty_o <= !wbs_err_i;
                  state     <= RESP;
               end else if (wbs_ack_i) begin
                  wbs_cyc_o <= 1'b0;
                  wbs_stb_o <= 1'b0;
                  // Keep a buffered copy of the written word coherent.
                  if (buf_valid && (buf_tag == wbs_adr_o[aw-1:2]))
                     buf_data[8*lane_q +: 8] <= wbs_dat_o[7:0];
                  wbm_ack_o <= 1'b1;
                  state     <= RESP;
               end
            end

            RESP: begin
               wbm_ack_o <= 1'b0;
               wbm_err_o <= 1'b0;
               wbm_rty_o <= 1'b0;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_data_upsize.sv
// Bench for wb_data_upsize: one little-endian and one big-endian instance
// share a memory-backed slave model; a reference model of the read buffer
// predicts hit/miss, response kind, data and latency.
module tb_wb_data_upsize;

   localparam int K_NONE = 0;
   localparam int K_ACK  = 1;
   localparam int K_ERR  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   // master side, shared except cyc/inv
   logic [31:0] m_adr = '0;
   logic [7:0]  m_dat = '0;
   logic        m_we  = 1'b0;
   logic        m_stb = 1'b0;
   logic [1:0]  m_cyc = '0;
   logic [1:0]  m_inv = '0;

   logic [7:0]  m_rdat [2];
   logic [1:0]  m_ack, m_err, m_rty;
   logic [31:0] s_adr [2];
   logic [31:0] s_wdat [2];
   logic [3:0]  s_sel [2];
   logic [1:0]  s_we, s_cyc, s_stb;
   logic [2:0]  s_cti [2];
   logic [1:0]  s_bte [2];

   logic [31:0] s_rdat = '0;
   logic [1:0]  s_ack = '0, s_err = '0, s_rty = '0;

   wb_data_upsize #(.aw(32), .endian("little")) u_le (
      .wb_clk_i(clk), .wb_rst_i(rst), .inv_i(m_inv[0]),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_we_i(m_we),
      .wbm_cyc_i(m_cyc[0]), .wbm_stb_i(m_stb & m_cyc[0]),
      .wbm_cti_i(3'b000), .wbm_bte_i(2'b00),
      .wbm_dat_o(m_rdat[0]), .wbm_ack_o(m_ack[0]), .wbm_err_o(m_err[0]), .wbm_rty_o(m_rty[0]),
      .wbs_adr_o(s_adr[0]), .wbs_dat_o(s_wdat[0]), .wbs_sel_o(s_sel[0]), .wbs_we_o(s_we[0]),
      .wbs_cyc_o(s_cyc[0]), .wbs_stb_o(s_stb[0]), .wbs_cti_o(s_cti[0]), .wbs_bte_o(s_bte[0]),
      .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack[0]), .wbs_err_i(s_err[0]), .wbs_rty_i(s_rty[0]));

   wb_data_upsize #(.aw(32), .endian("big")) u_be (
      .wb_clk_i(clk), .wb_rst_i(rst), .inv_i(m_inv[1]),
      .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_we_i(m_we),
      .wbm_cyc_i(m_cyc[1]), .wbm_stb_i(m_stb & m_cyc[1]),
      .wbm_cti_i(3'b000), .wbm_bte_i(2'b00),
      .wbm_dat_o(m_rdat[1]), .wbm_ack_o(m_ack[1]), .wbm_err_o(m_err[1]), .wbm_rty_o(m_rty[1]),
      .wbs_adr_o(s_adr[1]), .wbs_dat_o(s_wdat[1]), .wbs_sel_o(s_sel[1]), .wbs_we_o(s_we[1]),
      .wbs_cyc_o(s_cyc[1]), .wbs_stb_o(s_stb[1]), .wbs_cti_o(s_cti[1]), .wbs_bte_o(s_bte[1]),
      .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack[1]), .wbs_err_i(s_err[1]), .wbs_rty_i(s_rty[1]));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- slave model ----------------
   logic [31:0] mem [0:1023];
   int          cur       = 0;
   int          slv_delay = 0;
   bit          slv_err   = 1'b0;
   int          slv_cnt   = 0;
   int          acc_count = 0;
   logic [31:0] last_adr  = '0;
   logic [31:0] last_wdat = '0;
   logic [3:0]  last_sel  = '0;

   always @(posedge clk) begin
      if (s_ack != 2'b00 || s_err != 2'b00 || s_rty != 2'b00) begin
         s_ack <= '0; s_err <= '0; s_rty <= '0;
         slv_cnt <= 0;
      end else if (s_cyc[cur] && s_stb[cur]) begin
         if (slv_cnt >= slv_delay) begin
            slv_cnt   <= 0;
            acc_count =  acc_count + 1;
            last_adr  =  s_adr[cur];
            last_sel  =  s_sel[cur];
            last_wdat =  s_wdat[cur];
            if (slv_err) begin
               s_err[cur] <= 1'b1;
            end else begin
               s_ack[cur] <= 1'b1;
               if (s_we[cur]) begin
                  for (int b = 0; b < 4; b++)
                     if (s_sel[cur][b]) mem[s_adr[cur][11:2]][8*b +: 8] = s_wdat[cur][8*b +: 8];
               end else begin
                  s_rdat <= mem[s_adr[cur][11:2]];
               end
            end
         end else begin
            slv_cnt <= slv_cnt + 1;
         end
      end else begin
         slv_cnt <= 0;
      end
   end

   // ---------------- reference model ----------------
   bit          mvalid [2];
   logic [29:0] mword  [2];

   function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] a, input bit big);
      int sh;
      sh = big ? 8 * (3 - int'(a)) : 8 * int'(a);
      return 8'((w >> sh) & 32'hFF);
   endfunction

   int          exp_kind = K_NONE;
   bit          exp_read = 1'b0;
   logic [7:0]  exp_dat  = '0;

   // Per-cycle check of both instances against the current expectation.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (m_ack[d] || m_err[d] || m_rty[d]) begin
               int k;
               k = (d == cur) ? exp_kind : K_NONE;
               chk($sformatf("resp_kind_d%0d", d),
                   {61'd0, m_rty[d], m_err[d], m_ack[d]},
                   (k == K_ACK) ? 64'd1 : (k == K_ERR) ? 64'd2 : 64'd0);
               if (k == K_ACK && exp_read && m_ack[d])
                  chk($sformatf("rd_data_d%0d", d), 64'(m_rdat[d]), 64'(exp_dat));
            end
            if (s_cyc[d]) begin
               chk($sformatf("slave_const_d%0d", d),
                   {59'd0, s_cti[d], s_bte[d]}, 64'd0);
               chk($sformatf("slave_word_adr_d%0d", d), 64'(s_adr[d][1:0]), 64'd0);
            end
         end
      end
   end

   // One master access with model prediction and latency/access-count checks.
   task automatic access(input int d, input logic [31:0] adr, input bit we,
                         input logic [7:0] wd, input bit inv, input bit serr,
                         input string name);
      bit hit;
      int cnt0, cycles;
      hit  = !we && mvalid[d] && (mword[d] == adr[31:2]) && !inv;
      cnt0 = acc_count;
      @(negedge clk);
      cur      = d;
      slv_err  = serr;
      exp_kind = (hit || !serr) ? K_ACK : K_ERR;
      exp_read = !we;
      exp_dat  = get_byte(mem[adr[11:2]], adr[1:0], d == 1);
      m_adr = adr; m_we = we; m_dat = wd; m_stb = 1'b1;
      m_cyc[d] = 1'b1; m_inv[d] = inv;
      cycles = 0;
      do begin
         @(negedge clk);
         m_inv[d] = 1'b0;
         cycles++;
      end while (!(m_ack[d] || m_err[d] || m_rty[d]) && cycles < 40);
      m_cyc[d] = 1'b0; m_stb = 1'b0; m_we = 1'b0;
      exp_kind = K_NONE;
      chk({name, "_latency"}, 64'(cycles), hit ? 64'd1 : 64'(slv_delay + 3));
      chk({name, "_slave_accesses"}, 64'(acc_count - cnt0), hit ? 64'd0 : 64'd1);
      if (inv) mvalid[d] = 1'b0;
      if (!hit) begin
         if (serr) mvalid[d] = 1'b0;
         else if (!we) begin mvalid[d] = 1'b1; mword[d] = adr[31:2]; end
      end
      slv_err = 1'b0;
   endtask

   function automatic logic [63:0] outs(input int d);
      return {m_rdat[d], m_ack[d], m_err[d], m_rty[d], s_sel[d], s_we[d], s_cyc[d], s_stb[d]}
             | 64'(s_adr[d]) | 64'(s_wdat[d]);
   endfunction

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h01010101;
      mem[32'h100 >> 2] = 32'h44332211;
      mem[32'h200 >> 2] = 32'h88776655;
      mvalid[0] = 1'b0; mvalid[1] = 1'b0;
      mword[0] = '0; mword[1] = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs_le", outs(0), 64'd0);
      chk("reset_outs_be", outs(1), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // little endian miss then hit within the same word
      access(0, 32'h101, 1'b0, 8'h00, 1'b0, 1'b0, "le_rd101");
      chk("le_rd101_data", 64'(m_rdat[0]), 64'h22);
      chk("le_rd101_adr", 64'(last_adr), 64'h100);
      chk("le_rd101_sel", 64'(last_sel), 64'hF);
      access(0, 32'h102, 1'b0, 8'h00, 1'b0, 1'b0, "le_rd102");
      chk("le_rd102_data", 64'(m_rdat[0]), 64'h33);

      // big endian read, write-through, re-read hit
      access(1, 32'h100, 1'b0, 8'h00, 1'b0, 1'b0, "be_rd100");
      chk("be_rd100_data", 64'(m_rdat[1]), 64'h44);
      access(1, 32'h103, 1'b1, 8'hAA, 1'b0, 1'b0, "be_wr103");
      chk("be_wr103_sel", 64'(last_sel), 64'h1);
      chk("be_wr103_dat", 64'(last_wdat), 64'hAAAAAAAA);
      chk("be_wr103_mem", 64'(mem[32'h100 >> 2]), 64'h443322AA);
      access(1, 32'h103, 1'b0, 8'h00, 1'b0, 1'b0, "be_rd103");
      chk("be_rd103_data", 64'(m_rdat[1]), 64'hAA);

      // slave error on read miss, then a fresh access
      access(0, 32'h200, 1'b0, 8'h00, 1'b0, 1'b1, "le_err200");
      access(0, 32'h200, 1'b0, 8'h00, 1'b0, 1'b0, "le_rd200");
      chk("le_rd200_data", 64'(m_rdat[0]), 64'h55);

      // inv_i with a would-be hit: memory changed behind the buffer
      mem[32'h200 >> 2] = 32'hDEADBEEF;
      access(0, 32'h202, 1'b0, 8'h00, 1'b1, 1'b0, "le_inv202");
      chk("le_inv202_data", 64'(m_rdat[0]), 64'hAD);

      // slower slave, miss latency scales
      slv_delay = 2;
      access(1, 32'h204, 1'b0, 8'h00, 1'b0, 1'b0, "be_slow204");
      slv_delay = 0;

      // master abort while slave stalls in RD
      slv_delay = 5;
      @(negedge clk);
      cur = 0;
      m_adr = 32'h300; m_we = 1'b0; m_stb = 1'b1; m_cyc[0] = 1'b1;
      @(negedge clk);
      chk("abort_cyc_before", 64'(s_cyc[0]), 64'd1);
      @(negedge clk);
      m_cyc[0] = 1'b0; m_stb = 1'b0;
      @(posedge clk); #1;
      chk("abort_cyc_after", 64'(s_cyc[0]), 64'd0);
      repeat (8) @(negedge clk);
      mvalid[0] = 1'b0;
      slv_delay = 0;
      access(0, 32'h201, 1'b0, 8'h00, 1'b0, 1'b0, "le_after_abort");
      chk("le_after_abort_data", 64'(m_rdat[0]), 64'hBE);

      // reset during a stalled write
      slv_delay = 5;
      @(negedge clk);
      cur = 1;
      m_adr = 32'h101; m_we = 1'b1; m_dat = 8'h55; m_stb = 1'b1; m_cyc[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_wr_outs", outs(1), 64'd0);
      @(negedge clk);
      rst = 1'b0; m_cyc[1] = 1'b0; m_stb = 1'b0; m_we = 1'b0;
      mvalid[0] = 1'b0; mvalid[1] = 1'b0;
      slv_delay = 0;
      repeat (8) @(negedge clk);
      chk("rst_in_wr_mem", 64'(mem[32'h100 >> 2]), 64'h443322AA);
      access(1, 32'h100, 1'b0, 8'h00, 1'b0, 1'b0, "be_after_rst");
      chk("be_after_rst_data", 64'(m_rdat[1]), 64'h44);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
